// File: rtl/ir_decode_stage.sv
// ----------------------------------------------------------------------------
// ir_decode_stage
//   Decode stage of a small 16-bit pipeline: 8 x 16-bit register file
//   (R0 hard-wired to zero, write-first bypass from writeback), load-use and
//   branch-operand hazard detection, BEQZ/JMP resolution in decode, and the
//   ID/EX pipeline register.
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   IR[15:0], PC[11:0]            instruction from fetch and its address
//   stall_e                       downstream stall, ID/EX holds
//   wb_en, wb_adr, wb_data        register-file write port from writeback
//   stall_f, stall_d, flush_d     fetch PC hold, fetch IR hold, fetch IR clear
//   PC_source, PC_offset[11:0]    redirect fetch to PC + PC_offset
//   ex_*                          ID/EX pipeline register contents
// ----------------------------------------------------------------------------
module ir_decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic [11:0] PC,
    input  logic        stall_e,
    input  logic        wb_en,
    input  logic [2:0]  wb_adr,
    input  logic [15:0] wb_data,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        PC_source,
    output logic [11:0] PC_offset,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [2:0]  ex_rd,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm,
    output logic        ex_wr,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic [11:0] ex_pc
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_BEQZ = 4'hB,
        OP_JMP  = 4'hC,
        OP_R13  = 4'hD,
        OP_R14  = 4'hE,
        OP_R15  = 4'hF
    } op_e;

    // ST_WARM covers the reset cycles and the first cycle after release,
    // during which IR is decoded as a NOP.
    typedef enum logic {
        ST_WARM,
        ST_RUN
    } run_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        wr;
        logic        mem_rd;
        logic        mem_wr;
        logic [11:0] pc;
    } idex_t;

    run_e        run_state, run_next;
    idex_t       idex, idex_next, dec;
    logic [15:0] regs [0:7];

    op_e         op;
    logic [2:0]  rd, rs, rt, src2_adr;
    logic [15:0] rs_val, src2_val;
    logic        uses_rs, uses_rt, uses_rd;
    logic        writes, is_ld, is_st, is_beqz, is_jmp, issue;
    logic        load_use, br_hazard, taken;
    logic [11:0] br_off;

    // ---------------- register file ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_adr != 3'd0)) begin
            regs[wb_adr] <= wb_data;
        end
    end

    // ---------------- field decode ----------------
    always_comb begin
        op       = op_e'(IR[15:12]);
        rd       = IR[11:9];
        rs       = IR[8:6];
        rt       = IR[5:3];
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        uses_rd  = 1'b0;
        writes   = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        is_beqz  = 1'b0;
        is_jmp   = 1'b0;
        issue    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                writes  = 1'b1;
                issue   = 1'b1;
            end
            OP_ADDI: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
                issue   = 1'b1;
            end
            OP_LD: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
                is_ld   = 1'b1;
                issue   = 1'b1;
            end
            OP_ST: begin
                uses_rs = 1'b1;
                uses_rd = 1'b1;
                is_st   = 1'b1;
                issue   = 1'b1;
            end
            OP_BEQZ: begin
                uses_rd = 1'b1;
                is_beqz = 1'b1;
            end
            OP_JMP: begin
                is_jmp = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Second read port serves rt for R-type, rd for ST and BEQZ.
    always_comb begin
        src2_adr = uses_rd ? rd : rt;

        if (rs == 3'd0)
            rs_val = '0;
        else if (wb_en && (wb_adr == rs))
            rs_val = wb_data;
        else
            rs_val = regs[rs];

        if (src2_adr == 3'd0)
            src2_val = '0;
        else if (wb_en && (wb_adr == src2_adr))
            src2_val = wb_data;
        else
            src2_val = regs[src2_adr];
    end

    // ---------------- hazards and branch resolution ----------------
    always_comb begin
        load_use  = idex.valid && idex.mem_rd &&
                    ((uses_rs && (idex.rd == rs)) ||
                     (uses_rt && (idex.rd == rt)) ||
                     (uses_rd && (idex.rd == rd)));
        br_hazard = is_beqz && idex.valid && idex.wr && (idex.rd == rd);
        taken     = is_jmp || (is_beqz && (src2_val == 16'd0));
        br_off    = is_jmp ? IR[11:0] : {{3{IR[8]}}, IR[8:0]};
    end

    always_comb begin
        dec = '0;
        if (issue) begin
            dec.valid  = 1'b1;
            dec.op     = IR[15:12];
            dec.rd     = rd;
            dec.a      = rs_val;
            dec.b      = (uses_rt || uses_rd) ? src2_val : 16'd0;
            dec.imm    = {{10{IR[5]}}, IR[5:0]};
            dec.wr     = writes && (rd != 3'd0);
            dec.mem_rd = is_ld;
            dec.mem_wr = is_st;
            dec.pc     = PC;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clock) begin
        if (reset)
            run_state <= ST_WARM;
        else
            run_state <= run_next;
    end

    // Priority: reset/warm-up > stall_e > hazard stall > branch redirect.
    // A branch held by a hazard resolves only once the hazard has cleared,
    // since the redirect branch is below the hazard branch.
    always_comb begin
        run_next  = ST_RUN;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        flush_d   = 1'b0;
        PC_source = 1'b0;
        PC_offset = '0;
        idex_next = '0;
        if (reset || (run_state == ST_WARM)) begin
            run_next = reset ? ST_WARM : ST_RUN;
        end else if (stall_e) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            idex_next = idex;
        end else if (load_use || br_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (taken) begin
            PC_source = 1'b1;
            flush_d   = 1'b1;
            PC_offset = br_off;
        end else begin
            idex_next = dec;
        end
    end

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clock) begin
        if (reset)
            idex <= '0;
        else
            idex <= idex_next;
    end

    assign ex_valid  = idex.valid;
    assign ex_op     = idex.op;
    assign ex_rd     = idex.rd;
    assign ex_a      = idex.a;
    assign ex_b      = idex.b;
    assign ex_imm    = idex.imm;
    assign ex_wr     = idex.wr;
    assign ex_mem_rd = idex.mem_rd;
    assign ex_mem_wr = idex.mem_wr;
    assign ex_pc     = idex.pc;

endmodule

// File: tb/tb_ir_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_ir_decode_stage
//   Directed, table-driven bench for ir_decode_stage. Each table row is one
//   cycle: inputs, the expected combinational control outputs in that cycle,
//   and the expected ID/EX contents after the following rising edge. Reset
//   corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_ir_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] IR;
    logic [11:0] PC;
    logic        stall_e;
    logic        wb_en;
    logic [2:0]  wb_adr;
    logic [15:0] wb_data;
    logic        stall_f, stall_d, flush_d, PC_source;
    logic [11:0] PC_offset;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_a, ex_b, ex_imm;
    logic        ex_wr, ex_mem_rd, ex_mem_wr;
    logic [11:0] ex_pc;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clock = ~clock;

    ir_decode_stage dut (
        .clock     (clock),
        .reset     (reset),
        .IR        (IR),
        .PC        (PC),
        .stall_e   (stall_e),
        .wb_en     (wb_en),
        .wb_adr    (wb_adr),
        .wb_data   (wb_data),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .flush_d   (flush_d),
        .PC_source (PC_source),
        .PC_offset (PC_offset),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .ex_rd     (ex_rd),
        .ex_a      (ex_a),
        .ex_b      (ex_b),
        .ex_imm    (ex_imm),
        .ex_wr     (ex_wr),
        .ex_mem_rd (ex_mem_rd),
        .ex_mem_wr (ex_mem_wr),
        .ex_pc     (ex_pc)
    );

    // ctl = {stall_f, stall_d, flush_d, PC_source, PC_offset}
    // ex  = {valid, op, rd, a, b, imm, wr, mem_rd, mem_wr, pc}
    typedef struct {
        logic [15:0] ir;
        logic [11:0] pc;
        logic        se;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [15:0] ctl;
        logic [70:0] ex;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] mk_ctl(input logic stall, input logic redirect,
                                           input logic [11:0] off);
        return {stall, stall, redirect, redirect, off};
    endfunction

    function automatic logic [70:0] mk_ex(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] imm, input logic wr,
                                          input logic mrd, input logic mwr,
                                          input logic [11:0] pc);
        return {1'b1, op, rd, a, b, imm, wr, mrd, mwr, pc};
    endfunction

    function automatic vec_t mk(input logic [15:0] ir, input logic [11:0] pc,
                                input logic se, input logic we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic [15:0] ctl,
                                input logic [70:0] ex);
        vec_t v;
        v.ir = ir; v.pc = pc; v.se = se; v.we = we; v.wa = wa; v.wd = wd;
        v.ctl = ctl; v.ex = ex;
        return v;
    endfunction

    function automatic logic [15:0] ctl_now();
        return {stall_f, stall_d, flush_d, PC_source, PC_offset};
    endfunction

    function automatic logic [70:0] ex_now();
        return {ex_valid, ex_op, ex_rd, ex_a, ex_b, ex_imm, ex_wr, ex_mem_rd, ex_mem_wr, ex_pc};
    endfunction

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clock);
        reset   = 1'b0;
        IR      = v.ir;
        PC      = v.pc;
        stall_e = v.se;
        wb_en   = v.we;
        wb_adr  = v.wa;
        wb_data = v.wd;
        #1;
        check($sformatf("ctl[%0d]", idx), 71'(ctl_now()), 71'(v.ctl));
        @(posedge clock);
        #1;
        check($sformatf("ex[%0d]", idx), ex_now(), v.ex);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] c0;
        logic [70:0] e0;
        c0 = '0;
        e0 = '0;

        // 0: first cycle after reset, JMP must not redirect; load R2=5
        vecs.push_back(mk(16'hC005, 12'h000, 0, 1, 3'd2, 16'h0005, c0, e0));
        // 1: NOP, load R3=7
        vecs.push_back(mk(16'h0000, 12'h001, 0, 1, 3'd3, 16'h0007, c0, e0));
        // 2: ADD R1,R2,R3
        vecs.push_back(mk(16'h1298, 12'h020, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h1, 3'd1, 16'h0005, 16'h0007, 16'h0018, 1, 0, 0, 12'h020)));
        // 3: ADD R5,R3,R0 with writeback R3=BEEF (bypass)
        vecs.push_back(mk(16'h1AC0, 12'h021, 0, 1, 3'd3, 16'hBEEF, c0,
                          mk_ex(4'h1, 3'd5, 16'hBEEF, 16'h0000, 16'h0000, 1, 0, 0, 12'h021)));
        // 4: SUB R0,R3,R2 -> no write
        vecs.push_back(mk(16'h20D0, 12'h022, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h2, 3'd0, 16'hBEEF, 16'h0005, 16'h0010, 0, 0, 0, 12'h022)));
        // 5: ADDI R4,R2,-1
        vecs.push_back(mk(16'h88BF, 12'h023, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h8, 3'd4, 16'h0005, 16'h0000, 16'hFFFF, 1, 0, 0, 12'h023)));
        // 6: ST R3,[R2+3]
        vecs.push_back(mk(16'hA683, 12'h024, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'hA, 3'd3, 16'h0005, 16'hBEEF, 16'h0003, 0, 0, 1, 12'h024)));
        // 7: LD R1,[R2+0]
        vecs.push_back(mk(16'h9280, 12'h025, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h9, 3'd1, 16'h0005, 16'h0000, 16'h0000, 1, 1, 0, 12'h025)));
        // 8: ADD R4,R1,R1 -> load-use stall, bubble
        vecs.push_back(mk(16'h1848, 12'h026, 0, 0, 3'd0, 16'h0000, mk_ctl(1, 0, 12'h000), e0));
        // 9: ADD retried, R1 arriving via writeback
        vecs.push_back(mk(16'h1848, 12'h026, 0, 1, 3'd1, 16'h0011, c0,
                          mk_ex(4'h1, 3'd4, 16'h0011, 16'h0011, 16'h0008, 1, 0, 0, 12'h026)));
        // 10: BEQZ R0,-2 at 0x010 -> taken, offset FFE
        vecs.push_back(mk(16'hB1FE, 12'h010, 0, 0, 3'd0, 16'h0000, mk_ctl(0, 1, 12'hFFE), e0));
        // 11: flushed IR
        vecs.push_back(mk(16'h0000, 12'h011, 0, 0, 3'd0, 16'h0000, c0, e0));
        // 12: BEQZ R2,+5 not taken (R2=5) -> bubble
        vecs.push_back(mk(16'hB405, 12'h012, 0, 0, 3'd0, 16'h0000, c0, e0));
        // 13: ADD R7,R0,R0
        vecs.push_back(mk(16'h1E00, 12'h030, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h1, 3'd7, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 12'h030)));
        // 14: BEQZ R7,+4 -> branch-operand hazard, no redirect
        vecs.push_back(mk(16'hBE04, 12'h031, 0, 0, 3'd0, 16'h0000, mk_ctl(1, 0, 12'h000), e0));
        // 15: hazard cleared -> redirect now
        vecs.push_back(mk(16'hBE04, 12'h031, 0, 0, 3'd0, 16'h0000, mk_ctl(0, 1, 12'h004), e0));
        // 16: ADDI R2,R2,1
        vecs.push_back(mk(16'h8481, 12'h040, 0, 0, 3'd0, 16'h0000, c0,
                          mk_ex(4'h8, 3'd2, 16'h0005, 16'h0000, 16'h0001, 1, 0, 0, 12'h040)));
        // 17-19: JMP under stall_e -> hold, no redirect
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(16'hC123, 12'h041, 1, 0, 3'd0, 16'h0000, mk_ctl(1, 0, 12'h000),
                              mk_ex(4'h8, 3'd2, 16'h0005, 16'h0000, 16'h0001, 1, 0, 0, 12'h040)));
        // 20: stall_e drops -> JMP redirects
        vecs.push_back(mk(16'hC123, 12'h041, 0, 0, 3'd0, 16'h0000, mk_ctl(0, 1, 12'h123), e0));
        // 21: write to R0 is ignored
        vecs.push_back(mk(16'h0000, 12'h042, 0, 1, 3'd0, 16'hFFFF, c0, e0));
        // 22: ADD R1,R0,R0 while writeback targets R0 -> no bypass
        vecs.push_back(mk(16'h1200, 12'h050, 0, 1, 3'd0, 16'hFFFF, c0,
                          mk_ex(4'h1, 3'd1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 12'h050)));
        // 23: reserved opcode 1101 -> NOP
        vecs.push_back(mk(16'hD123, 12'h051, 0, 0, 3'd0, 16'h0000, c0, e0));

        // ---------------- power-on reset ----------------
        reset = 1'b1; IR = '0; PC = '0; stall_e = 1'b0;
        wb_en = 1'b0; wb_adr = '0; wb_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_ex", ex_now(), e0);
        check("reset_ctl", 71'(ctl_now()), 71'(c0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // ---------------- reset while stalled ----------------
        run_vec(mk(16'h9280, 12'h060, 0, 0, 3'd0, 16'h0000, c0,
                   mk_ex(4'h9, 3'd1, 16'h0005, 16'h0000, 16'h0000, 1, 1, 0, 12'h060)), 100);
        @(negedge clock);
        IR = 16'h1848; PC = 12'h061;
        #1;
        check("pre_reset_stall", 71'(stall_f), 71'(1'b1));
        reset = 1'b1;
        #1;
        check("in_reset_ctl", 71'(ctl_now()), 71'(c0));
        @(posedge clock);
        #1;
        check("after_reset_ex", ex_now(), e0);

        // reset held with a taken branch on IR: no redirect
        @(negedge clock);
        IR = 16'hB1FE;
        #1;
        check("reset_branch_ctl", 71'(ctl_now()), 71'(c0));

        // release: first cycle decodes IR as NOP
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("warm_ctl", 71'(ctl_now()), 71'(c0));
        @(posedge clock);
        #1;
        check("warm_ex", ex_now(), e0);

        // registers cleared by reset
        run_vec(mk(16'hA680, 12'h070, 0, 0, 3'd0, 16'h0000, c0,
                   mk_ex(4'hA, 3'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 12'h070)), 101);
        run_vec(mk(16'h1E48, 12'h071, 0, 0, 3'd0, 16'h0000, c0,
                   mk_ex(4'h1, 3'd7, 16'h0000, 16'h0000, 16'h0008, 1, 0, 0, 12'h071)), 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
